// File: rtl/regtest_pkg.sv
// rtl/regtest_pkg.sv - shared types and constants for the regression-test monitor
package regtest_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned SETTLE_W     = 16;

    localparam int unsigned DEF_DONE_REG = 26;
    localparam int unsigned DEF_PASS_REG = 27;
    localparam int unsigned DEF_TNUM_REG = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } regtest_state_e;

endpackage

// File: rtl/regtest_settle_timer.sv
// rtl/regtest_settle_timer.sv - loadable down-counter with zero flag for the settle window
module regtest_settle_timer
    import regtest_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic                zero_o
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/regtest_monitor.sv
// rtl/regtest_monitor.sv - snoops register-file writes and latches a pass/fail/timeout verdict
module regtest_monitor
    import regtest_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DONE_REG       = DEF_DONE_REG,
    parameter int unsigned PASS_REG       = DEF_PASS_REG,
    parameter int unsigned TNUM_REG       = DEF_TNUM_REG,
    parameter int unsigned SETTLE_CYCLES  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic                  clear_i,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  timeout_o,
    output logic [XLEN-1:0]       fail_tnum_o,
    output logic [31:0]           cycle_cnt_o
);

    localparam logic [REG_ADDR_W-1:0] DONE_IDX     = REG_ADDR_W'(DONE_REG);
    localparam logic [REG_ADDR_W-1:0] PASS_IDX     = REG_ADDR_W'(PASS_REG);
    localparam logic [REG_ADDR_W-1:0] TNUM_IDX     = REG_ADDR_W'(TNUM_REG);
    localparam logic [SETTLE_W-1:0]   SETTLE_LD    = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [31:0]           TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam bit                    TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [XLEN-1:0]       XONE         = XLEN'(1);

    regtest_state_e  state_q, state_d;
    logic [XLEN-1:0] sh_pass_q, sh_pass_d;
    logic [XLEN-1:0] sh_tnum_q, sh_tnum_d;
    logic [31:0]     run_cnt_q, run_cnt_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic            timeout_q, timeout_d;
    logic [XLEN-1:0] fail_tnum_q, fail_tnum_d;

    logic            settle_load;
    logic            settle_dec;
    logic            settle_zero;

    // Index 0 is the hard-wired zero register; its writes never reach the shadows.
    logic            wr_live;
    logic            done_wr;
    logic            pass_wr;
    logic            tnum_wr;

    assign wr_live = wr_en_i && (wr_addr_i != '0);
    assign done_wr = wr_live && (wr_addr_i == DONE_IDX) && (wr_data_i == XONE);
    assign pass_wr = wr_live && (wr_addr_i == PASS_IDX);
    assign tnum_wr = wr_live && (wr_addr_i == TNUM_IDX);

    regtest_settle_timer u_settle (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear_i),
        .load_i     (settle_load),
        .load_val_i (SETTLE_LD),
        .dec_i      (settle_dec),
        .zero_o     (settle_zero)
    );

    always_comb begin
        state_d     = state_q;
        sh_pass_d   = sh_pass_q;
        sh_tnum_d   = sh_tnum_q;
        run_cnt_d   = run_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_tnum_d = fail_tnum_q;
        settle_load = 1'b0;
        settle_dec  = 1'b0;

        if (clear_i) begin
            state_d     = ST_RUN;
            sh_pass_d   = '0;
            sh_tnum_d   = '0;
            run_cnt_d   = '0;
            cycle_cnt_d = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
            timeout_d   = 1'b0;
            fail_tnum_d = '0;
        end else begin
            if (state_q != ST_REPORT) begin
                if (pass_wr) begin
                    sh_pass_d = wr_data_i;
                end
                if (tnum_wr) begin
                    sh_tnum_d = wr_data_i;
                end
                if (cycle_cnt_q != 32'hFFFF_FFFF) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
            end

            // Verdicts read the shadows as they stood before this edge, so a
            // write landing on the transition edge cannot sway the result.
            unique case (state_q)
                ST_RUN: begin
                    if (done_wr) begin
                        state_d     = ST_SETTLE;
                        settle_load = 1'b1;
                    end else if (TIMEOUT_EN && (run_cnt_q == TIMEOUT_LAST)) begin
                        state_d     = ST_REPORT;
                        done_d      = 1'b1;
                        pass_d      = 1'b0;
                        fail_d      = 1'b1;
                        timeout_d   = 1'b1;
                        fail_tnum_d = sh_tnum_q;
                    end else if (TIMEOUT_EN) begin
                        run_cnt_d = run_cnt_q + 32'd1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_zero) begin
                        state_d     = ST_REPORT;
                        done_d      = 1'b1;
                        pass_d      = (sh_pass_q == XONE);
                        fail_d      = (sh_pass_q != XONE);
                        timeout_d   = 1'b0;
                        fail_tnum_d = (sh_pass_q == XONE) ? '0 : sh_tnum_q;
                    end else begin
                        settle_dec = 1'b1;
                    end
                end
                ST_REPORT: begin
                    state_d = ST_REPORT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            sh_pass_q   <= '0;
            sh_tnum_q   <= '0;
            run_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_tnum_q <= '0;
        end else begin
            state_q     <= state_d;
            sh_pass_q   <= sh_pass_d;
            sh_tnum_q   <= sh_tnum_d;
            run_cnt_q   <= run_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_tnum_q <= fail_tnum_d;
        end
    end

    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign fail_tnum_o = fail_tnum_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_regtest_monitor.sv
// tb/tb_regtest_monitor.sv - scoreboard bench for regtest_monitor (default and short-watchdog instances)
module tb_regtest_monitor;

    logic        clk = 1'b0;
    int          edge_cnt = 0;

    // instance A: defaults; instance B: TIMEOUT_CYCLES=20
    logic        rst_a = 1'b1, en_a = 1'b0, clr_a = 1'b0;
    logic [4:0]  addr_a = '0;
    logic [31:0] data_a = '0;
    logic        done_a, pass_a, fail_a, to_a;
    logic [31:0] tnum_a, cnt_a;

    logic        rst_b = 1'b1, en_b = 1'b0, clr_b = 1'b0;
    logic [4:0]  addr_b = '0;
    logic [31:0] data_b = '0;
    logic        done_b, pass_b, fail_b, to_b;
    logic [31:0] tnum_b, cnt_b;

    typedef struct {
        int          edge_n;
        logic        pass;
        logic        fail;
        logic        to;
        logic [31:0] tnum;
        logic [31:0] cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_chk  = 0;
    int n_fail = 0;
    int arm_a  = 0;
    int arm_b  = 0;
    int n      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    regtest_monitor u_dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .wr_en_i     (en_a),
        .wr_addr_i   (addr_a),
        .wr_data_i   (data_a),
        .clear_i     (clr_a),
        .done_o      (done_a),
        .pass_o      (pass_a),
        .fail_o      (fail_a),
        .timeout_o   (to_a),
        .fail_tnum_o (tnum_a),
        .cycle_cnt_o (cnt_a)
    );

    regtest_monitor #(.TIMEOUT_CYCLES(20)) u_dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .wr_en_i     (en_b),
        .wr_addr_i   (addr_b),
        .wr_data_i   (data_b),
        .clear_i     (clr_b),
        .done_o      (done_b),
        .pass_o      (pass_b),
        .fail_o      (fail_b),
        .timeout_o   (to_b),
        .fail_tnum_o (tnum_b),
        .cycle_cnt_o (cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are applied at a negedge and sampled by the following posedge.
    task automatic step(input int sel, input logic en, input logic [4:0] a,
                        input logic [31:0] d, input logic clr, input logic r);
        if (sel == 0) begin
            en_a = en; addr_a = a; data_a = d; clr_a = clr; rst_a = r;
            en_b = 1'b0; clr_b = 1'b0;
        end else begin
            en_b = en; addr_b = a; data_b = d; clr_b = clr; rst_b = r;
            en_a = 1'b0; clr_a = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int sel, input int cycles);
        for (int i = 0; i < cycles; i++) step(sel, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input int sel, input int edge_n, input logic p, input logic f,
                        input logic t, input logic [31:0] tn, input logic [31:0] cy);
        exp_t e;
        e.edge_n = edge_n; e.pass = p; e.fail = f; e.to = t; e.tnum = tn; e.cyc = cy;
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    task automatic chk_zero(input int sel, input string tag);
        if (sel == 0) begin
            chk({tag, "_done"}, done_a, 0); chk({tag, "_pass"}, pass_a, 0);
            chk({tag, "_fail"}, fail_a, 0); chk({tag, "_to"}, to_a, 0);
            chk({tag, "_tnum"}, tnum_a, 0); chk({tag, "_cnt"}, cnt_a, 0);
        end else begin
            chk({tag, "_done"}, done_b, 0); chk({tag, "_pass"}, pass_b, 0);
            chk({tag, "_fail"}, fail_b, 0); chk({tag, "_to"}, to_b, 0);
            chk({tag, "_tnum"}, tnum_b, 0); chk({tag, "_cnt"}, cnt_b, 0);
        end
    endtask

    task automatic do_clear(input int sel, input string tag);
        if (sel == 0) arm_a = edge_cnt + 1;
        else          arm_b = edge_cnt + 1;
        step(sel, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk_zero(sel, tag);
    endtask

    task automatic check_verdict(input int sel);
        exp_t        e;
        logic        p, f, t;
        logic [31:0] tn, cy;
        if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_verdict_%0d: got done at edge %0d expected none", sel, edge_cnt);
            return;
        end
        if (sel == 0) begin
            e = q_a.pop_front();
            p = pass_a; f = fail_a; t = to_a; tn = tnum_a; cy = cnt_a;
        end else begin
            e = q_b.pop_front();
            p = pass_b; f = fail_b; t = to_b; tn = tnum_b; cy = cnt_b;
        end
        chk($sformatf("v%0d_edge", sel), edge_cnt, e.edge_n);
        chk($sformatf("v%0d_pass", sel), p, e.pass);
        chk($sformatf("v%0d_fail", sel), f, e.fail);
        chk($sformatf("v%0d_timeout", sel), t, e.to);
        chk($sformatf("v%0d_tnum", sel), tn, e.tnum);
        chk($sformatf("v%0d_cycles", sel), cy, e.cyc);
    endtask

    logic done_a_d = 1'b0;
    logic done_b_d = 1'b0;

    // Monitor: every rising done_o consumes one expected verdict.
    always @(negedge clk) begin
        if (done_a === 1'b1 && done_a_d !== 1'b1) check_verdict(0);
        if (done_b === 1'b1 && done_b_d !== 1'b1) check_verdict(1);
        done_a_d = done_a;
        done_b_d = done_b;
    end

    initial begin
        @(negedge clk);

        // reset state, instance A
        step(0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        arm_a = edge_cnt + 1;
        step(0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk_zero(0, "reset_a");

        // pass run: x27=1, x26=1 at edge 50 -> verdict at edge 61
        step(0, 1'b1, 5'd27, 32'd1, 1'b0, 1'b0);
        while (edge_cnt + 1 < arm_a + 50) idle(0, 1);
        n = edge_cnt + 1;
        step(0, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        push(0, n + 11, 1'b1, 1'b0, 1'b0, 32'd0, 32'd61);
        idle(0, 15);
        chk("pass_hold_done", done_a, 1);
        chk("pass_hold_cnt", cnt_a, 61);
        do_clear(0, "clear1");

        // fail run: x3=7, x27=0, x26=1
        step(0, 1'b1, 5'd3, 32'd7, 1'b0, 1'b0);
        step(0, 1'b1, 5'd27, 32'd0, 1'b0, 1'b0);
        n = edge_cnt + 1;
        step(0, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        push(0, n + 11, 1'b0, 1'b1, 1'b0, 32'd7, 32'(n + 11 - arm_a));
        idle(0, 13);
        do_clear(0, "clear2");

        // late pass write three edges into SETTLE still counts
        n = edge_cnt + 1;
        step(0, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        idle(0, 2);
        step(0, 1'b1, 5'd27, 32'd1, 1'b0, 1'b0);
        push(0, n + 11, 1'b1, 1'b0, 1'b0, 32'd0, 32'(n + 11 - arm_a));
        idle(0, 12);
        do_clear(0, "clear3");

        // pass write on the REPORT transition edge is excluded
        n = edge_cnt + 1;
        step(0, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        idle(0, 10);
        step(0, 1'b1, 5'd27, 32'd1, 1'b0, 1'b0);
        push(0, n + 11, 1'b0, 1'b1, 1'b0, 32'd0, 32'(n + 11 - arm_a));
        idle(0, 4);
        do_clear(0, "clear4");

        // filtering: wrong value, index 0, disabled enable
        step(0, 1'b1, 5'd26, 32'd2, 1'b0, 1'b0);
        step(0, 1'b1, 5'd0, 32'd1, 1'b0, 1'b0);
        step(0, 1'b0, 5'd26, 32'd1, 1'b0, 1'b0);
        step(0, 1'b0, 5'd27, 32'd1, 1'b0, 1'b0);
        idle(0, 14);
        chk("filter_no_done", done_a, 0);
        chk("filter_cnt_run", cnt_a, 32'(edge_cnt - arm_a));
        n = edge_cnt + 1;
        step(0, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        push(0, n + 11, 1'b0, 1'b1, 1'b0, 32'd0, 32'(n + 11 - arm_a));
        idle(0, 13);
        do_clear(0, "clear5");

        // clear mid-SETTLE abandons the verdict
        step(0, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        idle(0, 3);
        do_clear(0, "clear_settle");
        idle(0, 15);
        chk("clear_abandon_done", done_a, 0);

        // rst mid-SETTLE abandons the verdict, then a fresh pass sequence
        step(0, 1'b1, 5'd27, 32'd1, 1'b0, 1'b0);
        step(0, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        idle(0, 4);
        arm_a = edge_cnt + 1;
        step(0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        idle(0, 15);
        chk("rst_abandon_done", done_a, 0);
        step(0, 1'b1, 5'd27, 32'd1, 1'b0, 1'b0);
        n = edge_cnt + 1;
        step(0, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        push(0, n + 11, 1'b1, 1'b0, 1'b0, 32'd0, 32'(n + 11 - arm_a));
        idle(0, 13);

        // instance B: watchdog fires at edge 20 after arming
        arm_b = edge_cnt + 1;
        step(1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk_zero(1, "reset_b");
        idle(1, 2);
        step(1, 1'b1, 5'd3, 32'd9, 1'b0, 1'b0);
        push(1, arm_b + 20, 1'b0, 1'b1, 1'b1, 32'd9, 32'd20);
        idle(1, 22);
        chk("to_hold_cnt", cnt_b, 20);
        do_clear(1, "clear_b1");

        // done write at edge 19 beats the watchdog
        step(1, 1'b1, 5'd27, 32'd1, 1'b0, 1'b0);
        while (edge_cnt + 1 < arm_b + 19) idle(1, 1);
        n = edge_cnt + 1;
        step(1, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        push(1, n + 11, 1'b1, 1'b0, 1'b0, 32'd0, 32'd30);
        idle(1, 13);
        do_clear(1, "clear_b2");

        // done write on the timeout edge itself: done wins
        while (edge_cnt + 1 < arm_b + 20) idle(1, 1);
        n = edge_cnt + 1;
        step(1, 1'b1, 5'd26, 32'd1, 1'b0, 1'b0);
        push(1, n + 11, 1'b0, 1'b1, 1'b0, 32'd0, 32'd31);
        idle(1, 13);

        chk("sb_a_drained", q_a.size(), 0);
        chk("sb_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regtest_monitor.md
# regtest_monitor

Synthesizable pass/fail monitor for the RISC-V SoC's ISA test flow, replacing the fixed "wait for x26, check x27, print x3" bench logic with parametrised RTL. It snoops the register-file write port and captures the pass flag and test number. After a settle delay it latches a verdict; a watchdog timeout ends a hung run. It sits beside `open_risc_v`'s register file, and its outputs drive bench checks, LEDs or a status register.

## Interface
- `XLEN`, 32, data width of the write port and captured values
- `DONE_REG`, 26, register index whose write of value 1 ends the test
- `PASS_REG`, 27, register index whose value 1 at verdict time means pass
- `TNUM_REG`, 3, register index holding the current test number
- `SETTLE_CYCLES`, 10, cycles between the done write and the verdict
- `TIMEOUT_CYCLES`, 100000, cycles in RUN before timeout; 0 disables the timeout
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `wr_en_i` in 1: register-file write enable
- `wr_addr_i` in 5: register-file write index
- `wr_data_i` in XLEN: register-file write data
- `clear_i` in 1: re-arm the monitor; takes effect in any state
- `done_o` out 1: verdict valid
- `pass_o` out 1: test passed; valid only while `done_o` is high
- `fail_o` out 1: test failed or timed out; valid only while `done_o` is high
- `timeout_o` out 1: verdict was caused by the watchdog
- `fail_tnum_o` out XLEN: shadow of `TNUM_REG` at verdict; 0 on pass
- `cycle_cnt_o` out 32: cycles spent in RUN+SETTLE since the last reset or clear; saturates at 0xFFFF_FFFF

## Operation
- Parameter constraints:
  - `DONE_REG`, `PASS_REG` and `TNUM_REG` are nonzero and pairwise distinct.
  - `SETTLE_CYCLES` is less than 2^16.
- Shadow registers `sh_pass` and `sh_tnum`:
  - A write updates them when `wr_en_i` is high and `wr_addr_i` matches the register's index.
  - They update in RUN and SETTLE only; they freeze in REPORT.
  - Writes to index 0 are ignored.
- State machine: RUN, SETTLE, REPORT.
- RUN:
  - `wr_en_i` with `wr_addr_i`==DONE_REG and `wr_data_i`==1 moves to SETTLE and loads the settle counter with `SETTLE_CYCLES`.
  - A write of any other value to DONE_REG is ignored.
  - With `TIMEOUT_CYCLES`≠0, when the RUN counter reaches `TIMEOUT_CYCLES`-1 the monitor moves to REPORT with `timeout_o`=1 and `fail_o`=1.
- SETTLE:
  - At a counter value of 0, moves to REPORT. Otherwise the counter decrements.
  - Further DONE_REG writes are ignored.
  - The watchdog is frozen.
- REPORT entry:
  - `pass_o` = (sh_pass==1), where sh_pass is the value before the transition edge.
  - `fail_o` = !`pass_o`.
  - `fail_tnum_o` = `pass_o` ? 0 : sh_tnum.
  - A write sampled on the transition edge is excluded from the verdict.
- REPORT: all outputs hold until `clear_i` or `rst`.
- `clear_i`:
  - Returns to RUN next edge.
  - Zeroes the shadows, both counters and all verdict outputs.
  - Has priority over every other event on the same edge.
- Simultaneous done write and timeout in RUN: the done write wins (go to SETTLE, no timeout).

## Timing
- Reset values:
  - All outputs are 0.
  - State is RUN; shadows and counters are 0.
  - The monitor is armed immediately after `rst` deasserts.
- Reset or clear mid-SETTLE abandons the pending verdict; no `done_o` pulse is produced.
- Verdict latency: `done_o` rises on edge N+SETTLE_CYCLES+1, where edge N samples the done write. With `SETTLE_CYCLES`=0 this is edge N+1.
- Timeout latency: `done_o` rises on edge `TIMEOUT_CYCLES` after arming.
- `cycle_cnt_o` increments on every edge in RUN or SETTLE and stops in REPORT.
- All outputs are registered; there is no combinational path from the inputs.

## Structure
- `regtest_pkg`:
  - state enum (RUN, SETTLE, REPORT)
  - default register-index constants (26, 27, 3)
  - `REG_ADDR_W`=5
- Sub-module `regtest_settle_timer`: loadable 16-bit down-counter with zero flag, used for SETTLE. The watchdog and cycle counter stay inline.

## Test plan
- Pass run, defaults: write x27=1, then x26=1 at edge 50 → `done_o`=1 at edge 61, `pass_o`=1, `fail_o`=0, `fail_tnum_o`=0.
- Fail run:
  - Stimulus: x3=7, x27=0, x26=1.
  - Required response: `fail_o`=1, `fail_tnum_o`=7, `timeout_o`=0.
  - Then `clear_i` → all outputs 0 on the next edge.
- Late pass write: x26=1, then x27=1 three edges later (SETTLE_CYCLES=10) → `pass_o`=1. The same write on the REPORT transition edge → `fail_o`=1.
- Timeout:
  - With TIMEOUT_CYCLES=20 and no writes → `done_o`, `timeout_o`, `fail_o`=1 at edge 20; `cycle_cnt_o`=20.
  - A done write at edge 19 → no timeout.
- Filtering: x26=2, a write to x0, and x26=1 with `wr_en_i`=0 → monitor stays in RUN.
- `rst` asserted during SETTLE → no `done_o`; a fresh x27=1, x26=1 sequence passes normally.
